// File: rtl/term_evaluator.sv
// Sequential evaluator for one polynomial term: result = coef * x^exp, computed
// by repeated multiplication at one multiply per clock, with overflow and range flags.
module term_evaluator #(
  parameter int RW      = 32,
  parameter int MAX_EXP = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    coef,
  input  logic [7:0]    exp,
  input  logic [3:0]    x,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] result,
  output logic          overflow,
  output logic          err
);

  typedef enum logic {IDLE, MULT} state_t;

  state_t          state, state_next;
  logic [RW-1:0]   acc;
  logic [3:0]      cnt;
  logic [3:0]      xr;
  logic            reject;
  logic            legal;
  logic            accept;
  logic            reject_set;
  logic [RW+3:0]   p;

  assign legal = (exp <= 8'(MAX_EXP));
  assign p     = (RW+4)'(acc) * (RW+4)'(xr);
  assign busy  = (state == MULT);

  // A rejected start holds the FSM in IDLE for one cycle so its done pulse
  // lands with the same latency as an exp=0 evaluation.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject_set = 1'b0;
    case (state)
      IDLE: begin
        if (start && !reject) begin
          if (legal) begin
            accept     = 1'b1;
            state_next = MULT;
          end else begin
            reject_set = 1'b1;
          end
        end
      end
      MULT: begin
        if (cnt == 4'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      xr       <= '0;
      reject   <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      state  <= state_next;
      done   <= 1'b0;
      reject <= reject_set;
      if (accept) begin
        acc      <= RW'(coef);
        cnt      <= exp[3:0];
        xr       <= x;
        overflow <= 1'b0;
        err      <= 1'b0;
      end
      if (reject) begin
        done     <= 1'b1;
        result   <= '0;
        err      <= 1'b1;
        overflow <= 1'b0;
      end
      if (state == MULT) begin
        if (cnt != 4'd0) begin
          // Truncate each step; any bits above RW mark the final value as wrapped.
          acc      <= p[RW-1:0];
          overflow <= overflow | (|p[RW+3:RW]);
          cnt      <= cnt - 4'd1;
        end else begin
          result <= acc;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_term_evaluator.sv
// Scoreboard bench for term_evaluator: stimulus pushes expected results,
// a negedge monitor pops and checks whenever done pulses.
module tb_term_evaluator;

  localparam int RW = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [7:0]    coef;
  logic [7:0]    exp_in;
  logic [3:0]    x;
  logic          busy;
  logic          done;
  logic [RW-1:0] result;
  logic          overflow;
  logic          err;

  term_evaluator #(.RW(RW), .MAX_EXP(14)) dut (
    .clk(clk), .rst(rst), .start(start), .coef(coef), .exp(exp_in), .x(x),
    .busy(busy), .done(done), .result(result), .overflow(overflow), .err(err)
  );

  typedef struct {
    logic [RW-1:0] e_res;
    logic          e_ov;
    logic          e_err;
    int            e_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: each done pulse must match the oldest expected entry, at the expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b0) begin
      prev_done = 1'b0;
    end else begin
      if (done === 1'b1) begin
        chk("done_not_consecutive", {63'd0, prev_done}, 64'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("result",   {32'd0, result}, {32'd0, e.e_res});
          chk("overflow", {63'd0, overflow}, {63'd0, e.e_ov});
          chk("err",      {63'd0, err}, {63'd0, e.e_err});
          chk("latency",  64'(cyc), 64'(e.e_cyc));
        end
      end
      prev_done = (done === 1'b1);
    end
  end

  task automatic push(input logic [RW-1:0] r, input logic ov, input logic er, input int c);
    exp_t e;
    e.e_res = r; e.e_ov = ov; e.e_err = er; e.e_cyc = c;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [7:0] c, input logic [7:0] e, input logic [3:0] xv,
                       output int e0);
    @(negedge clk);
    start = 1'b1; coef = c; exp_in = e; x = xv;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
    coef = 8'($urandom); exp_in = 8'($urandom); x = 4'($urandom);
  endtask

  // Counts busy over the lat cycles before done, then steps onto the done cycle.
  task automatic wait_busy(input int lat, output int nb);
    nb = 0;
    repeat (lat) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},     {63'd0, busy}, 64'd0);
    chk({tag, "_done"},     {63'd0, done}, 64'd0);
    chk({tag, "_result"},   {32'd0, result}, 64'd0);
    chk({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
    chk({tag, "_err"},      {63'd0, err}, 64'd0);
  endtask

  initial begin
    int e0, e1, nb;
    longint unsigned big;
    logic [RW-1:0] big_lo;
    big    = 64'd6568408355712890625;
    big_lo = big[RW-1:0];

    rst = 1'b1; start = 1'b0; coef = '0; exp_in = '0; x = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // 6 * 5^1
    issue(8'd6, 8'd1, 4'd5, e0);
    push(32'd30, 1'b0, 1'b0, e0 + 2);
    wait_busy(2, nb);
    chk("t1_busy_cycles", 64'(nb), 64'd2);

    // 12 * 0^0
    issue(8'd12, 8'd0, 4'd0, e0);
    push(32'd12, 1'b0, 1'b0, e0 + 1);
    wait_busy(1, nb);
    chk("t2_busy_cycles", 64'(nb), 64'd1);

    // 225 * 15^14 wraps
    issue(8'd225, 8'd14, 4'd15, e0);
    push(big_lo, 1'b1, 1'b0, e0 + 15);
    wait_busy(15, nb);
    chk("t3_busy_cycles", 64'(nb), 64'd15);

    // illegal exponent, then a legal start clears err
    issue(8'd9, 8'd20, 4'd3, e0);
    push(32'd0, 1'b0, 1'b1, e0 + 1);
    wait_busy(1, nb);
    chk("t4_busy_never", 64'(nb), 64'd0);
    issue(8'd3, 8'd2, 4'd2, e0);
    push(32'd12, 1'b0, 1'b0, e0 + 3);
    wait_busy(3, nb);
    chk("t4b_busy_cycles", 64'(nb), 64'd3);

    // 2 * 3^3 with an ignored mid-MULT start, then start on the done cycle
    issue(8'd2, 8'd3, 4'd3, e0);
    push(32'd54, 1'b0, 1'b0, e0 + 4);
    @(negedge clk);
    start = 1'b1; coef = 8'd1; exp_in = 8'd1; x = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_done_cycle", {63'd0, done}, 64'd1);
    start = 1'b1; coef = 8'd1; exp_in = 8'd1; x = 4'd7;
    @(posedge clk);
    #1;
    e1 = cyc;
    start = 1'b0;
    push(32'd7, 1'b0, 1'b0, e1 + 2);
    repeat (3) @(negedge clk);

    // reset mid-MULT aborts without a done pulse
    issue(8'd4, 8'd5, 4'd2, e0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    issue(8'd4, 8'd5, 4'd2, e0);
    push(32'd128, 1'b0, 1'b0, e0 + 6);
    wait_busy(6, nb);
    chk("t6_busy_cycles", 64'(nb), 64'd6);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/term_evaluator.md
# term_evaluator

Sequential evaluator for one differentiated polynomial term in the calculator datapath. It sits directly downstream of the derivative stage and consumes its coefficient output (`baseout`) and exponent output (`rootout`). Given a 4-bit evaluation point x, it computes coef·x^exp by repeated multiplication, one multiply per clock. It then presents the value to the display/accumulate stage with a one-cycle done pulse.

## Interface
- RW, default 32: result width in bits.
- MAX_EXP, default 14: largest legal exponent; 14 is the maximum the derivative stage produces from a 4-bit root.
- clk  in  1: single clock; all state changes on its rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: request evaluation; sampled only in IDLE.
- coef  in  8: term coefficient; connects to derivative `baseout`.
- exp  in  8: term exponent; connects to derivative `rootout`.
- x  in  4: evaluation point, unsigned 0..15.
- busy  out  1: high while in MULT.
- done  out  1: one-cycle pulse; result, overflow and err are valid from this cycle on.
- result  out  RW: lower RW bits of coef·x^exp; held until the next accepted start.
- overflow  out  1: any intermediate product exceeded RW bits; held with result.
- err  out  1: exp > MAX_EXP; held with result.

## Operation
- Reset: state IDLE; busy=0, done=0, result=0, overflow=0, err=0; internal acc, cnt and xr cleared.
- States: IDLE and MULT only.
- IDLE with start=1 and exp ≤ MAX_EXP:
  - acc←coef (zero-extended to RW), cnt←exp[3:0], xr←x.
  - overflow←0, err←0, state←MULT.
- IDLE with start=1 and exp > MAX_EXP:
  - State stays IDLE.
  - Next edge: done=1, result=0, err=1, overflow=0.
- MULT with cnt≠0:
  - p = acc·xr, computed at RW+4 bits.
  - acc←p[RW-1:0].
  - overflow←overflow | (p[RW+3:RW]≠0).
  - cnt←cnt−1.
- MULT with cnt=0: result←acc, done←1, state←IDLE.
- Operands are unsigned and there is no saturation; the result is truncated and overflow flags the truncation.
- x^0 = 1 for every x, including x=0, so exp=0 yields result=coef.
- coef=0 (the derivative stage's output for root=0 or base=0) runs the normal sequence and yields result=0.
- start while in MULT is ignored; coef, exp and x may change freely after acceptance.
- start in the same cycle that done is high is accepted, because state is IDLE then.
- rst asserted in any state, including mid-MULT, aborts the operation and returns to reset values on that edge; no done pulse is produced.

## Timing
- start sampled at edge E0 (legal exp): busy=1 from E0 until edge E0+exp+1.
- Multiplies occur at edges E0+1 .. E0+exp.
- Edge E0+exp+1: done=1 for exactly one cycle, busy=0, result valid.
- Latency from start to done is exp+1 cycles; worst case is MAX_EXP+1 = 15.
- Illegal exp: done at edge E0+1 (latency 1); busy never asserts.
- done is registered and never high for two consecutive cycles.
- Back-to-back throughput: one term per exp+1 cycles.

## Test plan
- coef=6, exp=1, x=5 (derivative of 3x²): start at E0 -> done at E0+2, result=30, overflow=0, err=0; busy high for exactly 2 cycles.
- coef=12, exp=0, x=0 -> done at E0+1, result=12 (0^0=1), overflow=0.
- coef=225, exp=14, x=15, RW=32 -> done at E0+15, result = lower 32 bits of 6568408355712890625, overflow=1.
- coef=9, exp=20 -> done at E0+1, result=0, err=1, busy never 1; a following legal start clears err.
- coef=2, exp=3, x=3, with a second start (coef=1, exp=1, x=7) asserted mid-MULT -> second start ignored, result=54 at E0+4. Then start at the done cycle with coef=1, exp=1, x=7 -> result=7 two cycles later.
- coef=4, exp=5, x=2, rst pulsed at E0+3 -> all outputs 0 from the next edge, no done pulse. A new start after reset yields result=128 at E0'+6.
